// File: rtl/game_pkg.sv
// Shared types and status codes for the number-guessing game.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    // Game-progress controller states.
    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        ADVANCE = 2'd1,
        LOSE    = 2'd2,
        WIN     = 2'd3
    } game_state_t;

    // win_or_lose encodings, also decoded by the display block.
    localparam logic [1:0] WOL_PLAY = 2'b11;
    localparam logic [1:0] WOL_LOSE = 2'b00;
    localparam logic [1:0] WOL_WIN  = 2'b01;

endpackage

// File: rtl/game_level_ctrl_edge.sv
// Rising-edge detector for a 1-bit level input (used on confirm_btn).
// Latency: rise is high in the first cycle d is seen high after being low.
// Backpressure: none; pure pulse generator.
// Ports: clk, rst_n (async active-low), d (level in), rise (edge pulse out).
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/game_level_ctrl.sv
// Game-progress controller: counts round wins / wrong guesses per level, escalates levels, declares WIN/LOSE.
// Latency: all outputs registered, one clk after the triggering input cycle.
// Backpressure: none; input pulses are consumed every cycle, ignored in ADVANCE/LOSE/WIN.
// Optional feature macro GAME_REPLAY_EN: confirm_btn rising edge in LOSE/WIN restarts the game.
// Ports: clk, restart (async active-low reset), round_win, wrong_guess, timeout, confirm_btn in;
//        level, max_digit, win_or_lose, guesses_left, rounds_won, level_up out.
module game_level_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LEVELS       = 3,
    parameter int ROUNDS_PER_LEVEL = 3,
    parameter int BASE_GUESSES     = 3,
    parameter int GUESS_STEP       = 1,
    parameter int LEVEL_W          = 2,
    parameter int ROUND_W          = 4,
    parameter int GUESS_W          = 3
) (
    input  logic               clk,
    input  logic               restart,
    input  logic               round_win,
    input  logic               wrong_guess,
    input  logic               timeout,
    input  logic               confirm_btn,
    output logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] max_digit,
    output logic [1:0]         win_or_lose,
    output logic [GUESS_W-1:0] guesses_left,
    output logic [ROUND_W-1:0] rounds_won,
    output logic               level_up
);

    // Wrong guesses allowed on a given level.
    function automatic logic [GUESS_W-1:0] guess_limit(input logic [LEVEL_W-1:0] lvl);
        guess_limit = GUESS_W'(BASE_GUESSES + int'(lvl) * GUESS_STEP);
    endfunction

    game_state_t        state_q,     state_d;
    logic [LEVEL_W-1:0] level_q,     level_d;
    logic [LEVEL_W-1:0] max_digit_q, max_digit_d;
    logic [1:0]         wol_q,       wol_d;
    logic [GUESS_W-1:0] guesses_q,   guesses_d;
    logic [ROUND_W-1:0] rounds_q,    rounds_d;
    logic               level_up_q,  level_up_d;

    logic               confirm_rise;
    logic [ROUND_W-1:0] rounds_inc;
    logic [LEVEL_W-1:0] level_inc;

`ifdef GAME_REPLAY_EN
    rise_edge_det u_confirm_edge (
        .clk   (clk),
        .rst_n (restart),
        .d     (confirm_btn),
        .rise  (confirm_rise)
    );
`else
    // Without replay, LOSE/WIN are terminal and the button is not observed.
    logic unused_confirm_btn;
    assign unused_confirm_btn = confirm_btn;
    assign confirm_rise       = 1'b0;
`endif

    assign rounds_inc = rounds_q + ROUND_W'(1);
    assign level_inc  = level_q + LEVEL_W'(1);

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        max_digit_d = max_digit_q;
        wol_d       = wol_q;
        guesses_d   = guesses_q;
        rounds_d    = rounds_q;
        level_up_d  = 1'b0;

        case (state_q)
            PLAY: begin
                if (timeout) begin
                    state_d   = LOSE;
                    wol_d     = WOL_LOSE;
                    guesses_d = '0;
                end else if (round_win) begin
                    // A round win in the same cycle as a wrong guess leaves the guess uncharged.
                    if (rounds_inc == ROUND_W'(ROUNDS_PER_LEVEL)) begin
                        if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
                            state_d   = WIN;
                            wol_d     = WOL_WIN;
                            guesses_d = '0;
                            rounds_d  = rounds_inc;
                        end else begin
                            // New level values are presented while ADVANCE is held,
                            // so level_up lines up with the refreshed level.
                            state_d     = ADVANCE;
                            level_d     = level_inc;
                            max_digit_d = max_digit_q + LEVEL_W'(1);
                            rounds_d    = '0;
                            guesses_d   = guess_limit(level_inc);
                            level_up_d  = 1'b1;
                        end
                    end else begin
                        rounds_d = rounds_inc;
                    end
                end else if (wrong_guess) begin
                    if (guesses_q == '0) begin
                        state_d = LOSE;
                        wol_d   = WOL_LOSE;
                    end else begin
                        guesses_d = guesses_q - GUESS_W'(1);
                    end
                end
            end
            ADVANCE: begin
                state_d = PLAY;
            end
            LOSE, WIN: begin
                if (confirm_rise) begin
                    state_d     = PLAY;
                    level_d     = '0;
                    max_digit_d = LEVEL_W'(1);
                    wol_d       = WOL_PLAY;
                    guesses_d   = guess_limit('0);
                    rounds_d    = '0;
                    level_up_d  = 1'b1;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_q     <= PLAY;
            level_q     <= '0;
            max_digit_q <= LEVEL_W'(1);
            wol_q       <= WOL_PLAY;
            guesses_q   <= GUESS_W'(BASE_GUESSES);
            rounds_q    <= '0;
            level_up_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            max_digit_q <= max_digit_d;
            wol_q       <= wol_d;
            guesses_q   <= guesses_d;
            rounds_q    <= rounds_d;
            level_up_q  <= level_up_d;
        end
    end

    assign level        = level_q;
    assign max_digit    = max_digit_q;
    assign win_or_lose  = wol_q;
    assign guesses_left = guesses_q;
    assign rounds_won   = rounds_q;
    assign level_up     = level_up_q;

endmodule
